// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size/exception encodings, FSM states and lane helpers for mem_access_unit
package mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_LMIS = 2'b01;
  localparam logic [1:0] EXC_SMIS = 2'b10;
  localparam logic [1:0] EXC_TOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_EXC,
    ST_TOUT
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

  // Natural-alignment of the low address bits, used when misalignment is not trapped.
  function automatic logic [1:0] aligned_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: return {lane[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-strobe/write-data lane replication and read-data shift/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        we,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [3:0]  strb;
  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    strb      = 4'b0000;
    shamt     = 5'd0;
    wdata_out = wdata_in;
    case (size)
      SZ_BYTE: begin
        strb      = 4'b0001 << lane;
        shamt     = {lane, 3'b000};
        wdata_out = {4{wdata_in[7:0]}};
      end
      SZ_HALF: begin
        strb      = 4'b0011 << {lane[1], 1'b0};
        shamt     = {lane[1], 4'b0000};
        wdata_out = {2{wdata_in[15:0]}};
      end
      SZ_WORD: begin
        strb      = 4'b1111;
      end
      default: begin
        strb      = 4'b0000;
      end
    endcase
  end

  assign shifted = rdata_in >> shamt;
  assign wstrb   = we ? strb : 4'b0000;

  always_comb begin
    rdata_out = shifted;
    case (size)
      SZ_BYTE: rdata_out = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_out = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: rdata_out = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator on a valid/ready data bus
// ALIGN_EXC_EN: when defined, misaligned half/word accesses trap instead of being force-aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  exc_code,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = 16;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW:0]  cnt_inc;
  logic         cnt_expired;
  logic [3:0]   lane_wstrb;
  logic [31:0]  lane_wdata;
  logic [31:0]  lane_rdata;

  mem_lane_align u_align (
    .size      (size_q),
    .we        (we_q),
    .sign      (sign_q),
    .lane      (addr_q[1:0]),
    .wdata_in  (wdata_q),
    .rdata_in  (bus_rdata),
    .wstrb     (lane_wstrb),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign cnt_expired = (cnt_inc == (CW+1)'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && (cpu_size != SZ_NONE)) begin
          we_d    = cpu_we;
          size_d  = cpu_size;
          sign_d  = cpu_sign;
          wdata_d = cpu_wdata;
          rdata_d = '0;
          exc_d   = EXC_NONE;
          cnt_d   = '0;
`ifdef ALIGN_EXC_EN
          addr_d  = cpu_addr;
          if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
            exc_d   = cpu_we ? EXC_SMIS : EXC_LMIS;
            state_d = ST_EXC;
          end else begin
            state_d = ST_REQ;
          end
`else
          addr_d  = {cpu_addr[31:2], aligned_lane(cpu_size, cpu_addr[1:0])};
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc[CW-1:0];
        // A store is complete once accepted, so it beats a coincident timeout.
        if (bus_ready && we_q) begin
          state_d = ST_DONE;
        end else if (cnt_expired) begin
          exc_d   = EXC_TOUT;
          state_d = ST_TOUT;
        end else if (bus_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc[CW-1:0];
        if (bus_rvalid) begin
          rdata_d = lane_rdata;
          state_d = ST_DONE;
        end else if (cnt_expired) begin
          exc_d   = EXC_TOUT;
          state_d = ST_TOUT;
        end
      end
      ST_DONE, ST_EXC, ST_TOUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_NONE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) || (state_q == ST_EXC) || (state_q == ST_TOUT);
  assign rdata     = done ? rdata_q : '0;
  assign exc_code  = done ? exc_q : EXC_NONE;
  assign bus_valid = (state_q == ST_REQ);
  assign bus_we    = bus_valid & we_q;
  assign bus_wstrb = bus_valid ? lane_wstrb : 4'b0000;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = lane_wdata;

endmodule
